// File: rtl/skew_feeder.sv
// -----------------------------------------------------------------------------
// skew_feeder
//   Drains `len` words from each of ROWS operand FIFOs in diagonal order so
//   that row r starts r steps after row 0, then presents the words at the
//   systolic-array edge. If any active row's FIFO is empty, the whole step
//   stalls so that the diagonal alignment is kept.
//
// Ports
//   clk         system clock (rising edge)
//   rst         synchronous active-high reset
//   start       launch pulse, sampled only in IDLE
//   len         words per row, captured with an accepted start
//   fifo_empty  per-row FIFO empty flags
//   fifo_data   per-row FIFO read data, valid one cycle after its read enable
//   fifo_r_en   per-row FIFO read enables (combinational)
//   a_out       per-row data to the array edge, zero when the lane is invalid
//   a_valid     per-row valid, read enable delayed by the FIFO latency
//   a_en        array advance enable, high one cycle after a fired step
//   busy        high in RUN and DRAIN
//   done        one-cycle completion pulse (the DRAIN cycle)
// -----------------------------------------------------------------------------

// Per-row lane: decides whether this row takes part in step t and gates the
// edge data with its valid bit.
module skew_feeder_lane #(
   parameter int ROW   = 0,
   parameter int WIDTH = 8,
   parameter int LEN_W = 8,
   parameter int T_W   = 11
) (
   input  logic [T_W-1:0]   i_t,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_active,
   output logic [WIDTH-1:0] o_data
);
   localparam logic [T_W-1:0] C_ROW = T_W'(ROW);

   logic [T_W-1:0] w_end;

   // Row is active for r <= t < r+len; T_W is wide enough that r+len never wraps.
   assign w_end    = C_ROW + T_W'(i_len);
   assign o_active = (i_t >= C_ROW) && (i_t < w_end);
   assign o_data   = i_valid ? i_data : '0;
endmodule

module skew_feeder #(
   parameter int ROWS  = 4,
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      len,
   input  logic [ROWS-1:0]       fifo_empty,
   input  logic [ROWS*WIDTH-1:0] fifo_data,
   output logic [ROWS-1:0]       fifo_r_en,
   output logic [ROWS*WIDTH-1:0] a_out,
   output logic [ROWS-1:0]       a_valid,
   output logic                  a_en,
   output logic                  busy,
   output logic                  done
);
   localparam int T_W = LEN_W + $clog2(ROWS) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       r_state;
   logic [LEN_W-1:0] r_len;
   logic [T_W-1:0]   r_t;
   logic [ROWS-1:0]  r_a_valid;
   logic             r_a_en;

   logic [ROWS-1:0]  w_active;
   logic             w_step_ok;
   logic             w_fire;
   logic             w_last;
   logic [T_W-1:0]   w_last_t;

   genvar g;
   generate
      for (g = 0; g < ROWS; g++) begin : g_lane
         skew_feeder_lane #(
            .ROW   (g),
            .WIDTH (WIDTH),
            .LEN_W (LEN_W),
            .T_W   (T_W)
         ) u_lane (
            .i_t      (r_t),
            .i_len    (r_len),
            .i_valid  (r_a_valid[g]),
            .i_data   (fifo_data[g*WIDTH +: WIDTH]),
            .o_active (w_active[g]),
            .o_data   (a_out[g*WIDTH +: WIDTH])
         );
      end
   endgenerate

   // A step fires only if every participating row has data; otherwise all
   // rows hold together.
   assign w_step_ok = ~|(fifo_empty & w_active);
   assign w_fire    = (r_state == S_RUN) && w_step_ok;

   // Reads are suppressed during reset so an aborted run never pops a FIFO.
   assign fifo_r_en = (w_fire && !rst) ? w_active : '0;

   // Final step index len+ROWS-2, evaluated at full counter width.
   assign w_last_t = T_W'(r_len) + T_W'(ROWS) - T_W'(2);
   assign w_last   = (r_t == w_last_t);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_len     <= '0;
         r_t       <= '0;
         r_a_valid <= '0;
         r_a_en    <= 1'b0;
      end else begin
         r_a_valid <= fifo_r_en;
         r_a_en    <= w_fire;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len   <= len;
                  r_t     <= '0;
                  // Zero-length request skips RUN and completes immediately.
                  r_state <= (len == '0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (w_fire) begin
                  if (w_last) r_state <= S_DRAIN;
                  else        r_t     <= r_t + T_W'(1);
               end
            end
            S_DRAIN: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign a_valid = r_a_valid;
   assign a_en    = r_a_en;
   assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done    = (r_state == S_DRAIN);
endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: stimulus pushes per-cycle expected outputs,
// an independent negedge monitor pops and compares.
module tb_skew_feeder;
   localparam int ROWS  = 4;
   localparam int WIDTH = 8;
   localparam int LEN_W = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic [LEN_W-1:0]      len = '0;
   logic [ROWS-1:0]       fifo_empty;
   logic [ROWS*WIDTH-1:0] fifo_data;
   logic [ROWS-1:0]       fifo_r_en;
   logic [ROWS*WIDTH-1:0] a_out;
   logic [ROWS-1:0]       a_valid;
   logic                  a_en;
   logic                  busy;
   logic                  done;

   skew_feeder #(.ROWS(ROWS), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_r_en(fifo_r_en),
      .a_out(a_out), .a_valid(a_valid), .a_en(a_en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // ---------------- FIFO model: row r word k = r*16+k, registered read ----
   int               fill_n = 0;
   logic             fifo_clr = 1'b1;
   logic [ROWS-1:0]  force_empty = '0;
   int               ptr [ROWS];
   logic [WIDTH-1:0] fq  [ROWS];

   function automatic logic [WIDTH-1:0] data_of(int r, int k);
      return WIDTH'(r*16 + k);
   endfunction

   always @(posedge clk) begin
      for (int r = 0; r < ROWS; r++) begin
         if (fifo_clr) begin
            ptr[r] <= 0;
            fq[r]  <= '0;
         end else if (fifo_r_en[r]) begin
            fq[r]  <= data_of(r, ptr[r]);
            ptr[r] <= ptr[r] + 1;
         end
      end
   end

   always_comb begin
      fifo_empty = '0;
      fifo_data  = '0;
      for (int r = 0; r < ROWS; r++) begin
         fifo_empty[r]            = (ptr[r] >= fill_n) || force_empty[r];
         fifo_data[r*WIDTH +: WIDTH] = fq[r];
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          id;
      logic [3:0]  ren;
      logic [3:0]  av;
      logic [31:0] aout;
      logic        aen;
      logic        bsy;
      logic        dn;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   kcnt[ROWS];
   exp_t me;

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         me = sbq.pop_front();
         checks++;
         if ({fifo_r_en, a_valid, a_out, a_en, busy, done} !==
             {me.ren, me.av, me.aout, me.aen, me.bsy, me.dn}) begin
            errors++;
            $display("FAIL cyc%0d: got ren=%b av=%b aout=%h aen=%b busy=%b done=%b want ren=%b av=%b aout=%h aen=%b busy=%b done=%b",
                     me.id, fifo_r_en, a_valid, a_out, a_en, busy, done,
                     me.ren, me.av, me.aout, me.aen, me.bsy, me.dn);
         end
      end
   end

   // Hand-computed per-cycle tables, index 0 = cycle 1 after start.
   logic [3:0] B_REN [8] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
   logic [3:0] B_AV  [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
   logic       B_AEN [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
   logic       B_BSY [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
   logic       B_DN  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

   logic [3:0] S_REN [9] = '{4'h1, 4'h3, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
   logic [3:0] S_AV  [9] = '{4'h0, 4'h1, 4'h3, 4'h0, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
   logic       S_AEN [9] = '{0, 1, 1, 0, 1, 1, 1, 1, 0};
   logic       S_BSY [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
   logic       S_DN  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

   task automatic reset_k();
      for (int r = 0; r < ROWS; r++) kcnt[r] = 0;
   endtask

   // Expected lane data follows the order each row's words become valid.
   task automatic push(int id, logic [3:0] ren, logic [3:0] av,
                       logic aen, logic bsy, logic dn);
      exp_t e;
      e.id = id; e.ren = ren; e.av = av; e.aen = aen; e.bsy = bsy; e.dn = dn;
      e.aout = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (av[r]) begin
            e.aout[r*WIDTH +: WIDTH] = data_of(r, kcnt[r]);
            kcnt[r]++;
         end
      end
      sbq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() > 0 && n < 2000) begin
         tick();
         n++;
      end
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d entries left, want 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic reload(int n);
      fill_n   = n;
      fifo_clr = 1'b1;
      tick();
      fifo_clr = 1'b0;
   endtask

   // Start is sampled at the next edge (edge 0); returns in cycle 1.
   task automatic launch(int l);
      start = 1'b1;
      len   = LEN_W'(l);
      tick();
      start = 1'b0;
   endtask

   task automatic push_basic(int base);
      reset_k();
      for (int c = 0; c < 8; c++)
         push(base + c + 1, B_REN[c], B_AV[c], B_AEN[c], B_BSY[c], B_DN[c]);
   endtask

   initial begin
      // Reset values
      tick();
      push(1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
      push(2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
      rst      = 1'b0;
      fifo_clr = 1'b0;
      drain();

      // Basic skew, len=3
      reload(3);
      launch(3);
      push_basic(100);
      drain();

      // Stall: row 1 empty during cycle 3
      reload(3);
      launch(3);
      reset_k();
      for (int c = 0; c < 9; c++)
         push(200 + c + 1, S_REN[c], S_AV[c], S_AEN[c], S_BSY[c], S_DN[c]);
      tick();                       // cycle 2
      tick();                       // cycle 3
      force_empty[1] = 1'b1;
      tick();                       // cycle 4
      force_empty[1] = 1'b0;
      drain();

      // len=0: no reads, done with busy in the single DRAIN cycle
      reload(3);
      launch(0);
      reset_k();
      push(301, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
      push(302, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      push(303, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      drain();

      // Re-start with len=5 during RUN is ignored
      reload(3);
      launch(3);
      push_basic(400);
      tick();                       // cycle 2
      tick();                       // cycle 3
      start = 1'b1;
      len   = 8'd5;
      tick();                       // cycle 4
      start = 1'b0;
      len   = 8'd0;
      drain();

      // Reset in cycle 3 aborts without done
      reload(3);
      launch(3);
      reset_k();
      push(501, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0);
      push(502, 4'h3, 4'h1, 1'b1, 1'b1, 1'b0);
      push(503, 4'h0, 4'h3, 1'b1, 1'b1, 1'b0);
      for (int c = 4; c <= 8; c++) push(500 + c, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();                       // cycle 2
      tick();                       // cycle 3
      rst = 1'b1;
      tick();                       // cycle 4
      rst = 1'b0;
      drain();

      // Fresh run after the abort
      reload(3);
      launch(3);
      push_basic(600);
      drain();

      // Maximum length 255: RUN for len+ROWS-1 cycles, done at cycle len+ROWS
      reload(255);
      launch(255);
      reset_k();
      begin
         logic [3:0] prev_ren;
         logic [3:0] ren;
         int         l;
         l        = 255;
         prev_ren = '0;
         for (int c = 1; c <= l + ROWS + 1; c++) begin
            ren = '0;
            if (c <= l + ROWS - 1)
               for (int r = 0; r < ROWS; r++)
                  ren[r] = (c - 1 >= r) && (c - 1 < r + l);
            push(1000 + c, ren, prev_ren, (c >= 2) && (c <= l + ROWS),
                 c <= l + ROWS, c == l + ROWS);
            prev_ren = ren;
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
